digit_scan_controller: RTL and testbench

Time-multiplexed scan controller for the 8-digit seven-segment display. It produces the 3-bit digit select that drives the address and data nibble multiplexers, and the matching active-low anode enables, from a prescaled refresh tick. It sits directly upstream of the nibble multiplexers: its `sel` output is their select input, and its `anode` output goes straight to the board's digit anodes.

---
 rtl/digit_scan_controller_pkg.sv | 25 ++
 rtl/digit_scan_controller_refresh_prescaler.sv | 37 +++
 rtl/digit_scan_controller.sv | 92 +++++++++
 tb/tb_digit_scan_controller.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/digit_scan_controller_pkg.sv
// Shared display definitions for the seven-segment digit scan path.
package digit_scan_controller_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEL_W      = 3;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

    typedef enum logic [SEL_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } scan_state_e;

    // S7 rolls over to S0 through the natural 3-bit wrap.
    function automatic scan_state_e next_digit(input scan_state_e s);
        return scan_state_e'(s + 3'd1);
    endfunction

endpackage

// File: rtl/digit_scan_controller_refresh_prescaler.sv
// Refresh prescaler: enabled modulo-TICK_DIV counter with a terminal-count pulse.
module refresh_prescaler #(
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last;

    assign last = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en & last & ~reset;

endmodule

// File: rtl/digit_scan_controller.sv
// 8-digit seven-segment scan controller: digit select plus active-low anodes.
// Optional ghost-suppression blanking is enabled with the SCAN_BLANK_EN macro.
module digit_scan_controller
    import digit_scan_controller_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [SEL_W-1:0]      sel,
    output logic [NUM_DIGITS-1:0] anode,
    output logic                  tick
);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("TICK_DIV must be at least 2");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= TICK_DIV) begin : g_bad_blank
        $error("BLANK_CYCLES must be in 1..TICK_DIV-1");
    end

    scan_state_e state_q;
    scan_state_e state_d;
    logic        blank_on;

    refresh_prescaler #(
        .TICK_DIV(TICK_DIV),
        .CNT_W   ($clog2(TICK_DIV))
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        if (tick) begin
            state_d = next_digit(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef SCAN_BLANK_EN
    localparam int BLK_W = $clog2(BLANK_CYCLES + 1);

    logic [BLK_W-1:0] blank_q;
    logic [BLK_W-1:0] blank_d;

    // Reload on every advance so each new slot opens dark.
    always_comb begin
        blank_d = blank_q;
        if (tick) begin
            blank_d = BLK_W'(BLANK_CYCLES);
        end else if (en && blank_q != '0) begin
            blank_d = blank_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank_on = (blank_q != '0);
`else
    assign blank_on = 1'b0;
`endif

    assign sel = state_q;

    always_comb begin
        anode = ANODE_OFF;
        if (!reset && en && !blank_on && digit_mask[sel]) begin
            anode[sel] = 1'b0;
        end
    end

endmodule

// File: tb/tb_digit_scan_controller.sv
// Scoreboard bench for digit_scan_controller with TICK_DIV=4, BLANK_CYCLES=2.
module tb_digit_scan_controller;

    localparam int TD  = 4;
    localparam int BLK = 2;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] anode;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] digit_mask;
    logic [2:0] sel;
    logic [7:0] anode;
    logic       tick;

    int n_chk = 0;
    int n_fail = 0;
    int m_cnt, m_st, m_blk;
    int obs_sel;
    exp_t sb[$];

    digit_scan_controller #(
        .TICK_DIV    (TD),
        .BLANK_CYCLES(BLK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .digit_mask(digit_mask),
        .sel       (sel),
        .anode     (anode),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        exp_t e;
        bit   tk;
        e.sel   = m_st[2:0];
        e.tick  = !reset && en && (m_cnt == TD - 1);
        e.anode = 8'hFF;
        if (!reset && en && m_blk == 0 && digit_mask[m_st[2:0]]) begin
            e.anode[m_st[2:0]] = 1'b0;
        end
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk("sel", int'(sel), int'(e.sel));
        chk("anode", int'(anode), int'(e.anode));
        chk("tick", int'(tick), int'(e.tick));
        obs_sel = int'(sel);
        @(posedge clk);
        if (reset) begin
            m_cnt = 0;
            m_st  = 0;
            m_blk = 0;
        end else if (en) begin
            tk    = (m_cnt == TD - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            if (tk) begin
                m_st = (m_st + 1) % 8;
`ifdef SCAN_BLANK_EN
                m_blk = BLK;
`endif
            end else if (m_blk > 0) begin
                m_blk = m_blk - 1;
            end
        end
        #1;
    endtask

    initial begin
        int  prev;
        int  wrap;
        int  k;
        bit  found;

        reset      = 1'b1;
        en         = 1'b0;
        digit_mask = 8'h00;
        m_cnt      = 0;
        m_st       = 0;
        m_blk      = 0;
        @(posedge clk);
        #1;
        en         = 1'b1;
        digit_mask = 8'hFF;
        repeat (3) cycle();

        reset = 1'b0;
        prev  = 0;
        wrap  = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (i > 0 && prev == 7 && obs_sel == 0 && wrap < 0) wrap = i;
            prev = obs_sel;
        end
        chk("wrap_cycle", wrap, 32);

        digit_mask = 8'b1010_1010;
        repeat (32) cycle();
        digit_mask = 8'hFF;

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_st == 3 && m_cnt == 2) found = 1'b1;
            else cycle();
        end
        chk("reach_s3_cnt2", int'(found), 1);
        en = 1'b0;
        repeat (5) cycle();
        en = 1'b1;
        k  = 0;
        do begin
            cycle();
            k++;
        end while (obs_sel == 3 && k < 10);
        chk("resume_cycles", k - 1, 2);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_st == 5 && m_cnt == TD - 1) found = 1'b1;
            else cycle();
        end
        chk("reach_s5_tick", int'(found), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk("rst_over_tick_sel", obs_sel, 0);
        repeat (24) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
